// File: rtl/bram_flush_pkg.sv
// Shared types and defaults for the BRAM flush controller.
package bram_flush_pkg;

  // Default geometry of the BRAM tile being flushed.
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 36;

  // Default word written into every flushed location; matches the
  // flush_opt logic1 constant (all ones).
  localparam logic [DATA_W_DEF-1:0] FILL_VALUE_DEF = {DATA_W_DEF{1'b1}};

  // Flush sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

endpackage : bram_flush_pkg

// File: rtl/bram_flush_addr_gen.sv
// Address walker for the flush: holds the current address and the latched
// last address, steps with natural ADDR_W-bit wrap, flags the last word.
module bram_flush_addr_gen
  import bram_flush_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] cur,
  output logic              last
);

  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] end_q;

  // Latch the range on load, otherwise advance one word per step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments and a synchronous
    // reset sampled on the clock edge, so every flop sees the same edge.
    if (reset) begin
      cur_q <= '0;
      end_q <= '0;
    end else if (load) begin
      cur_q <= start_addr;
      end_q <= last_addr;
    end else if (step) begin
      // Natural wrap DEPTH-1 -> 0 lets a range with end < start walk
      // across the top of the address space.
      cur_q <= cur_q + 1'b1;
    end
  end

  assign cur  = cur_q;
  // Equality only: the walk terminates solely on reaching the end address.
  assign last = (cur_q == end_q);

endmodule : bram_flush_addr_gen

// File: rtl/bram_flush_ctrl.sv
// BRAM flush controller: sits between the user write/read port and the BRAM
// primitive. While a flush runs it owns the write port and fills the latched
// address range with FILL_VALUE; reads always pass through, one cycle late.
module bram_flush_ctrl
  import bram_flush_pkg::*;
#(
  parameter int                 ADDR_W     = ADDR_W_DEF,
  parameter int                 DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  FILL_VALUE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_req,
  input  logic              flush_abort,
  input  logic [ADDR_W-1:0] flush_start,
  input  logic [ADDR_W-1:0] flush_end,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              flush_aborted,
  input  logic              usr_wen,
  input  logic [ADDR_W-1:0] usr_waddr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic              usr_wack,
  input  logic              usr_ren,
  input  logic [ADDR_W-1:0] usr_raddr,
  output logic              bram_wen,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_ren,
  output logic [ADDR_W-1:0] bram_raddr
);

  state_t            state, state_n;
  logic              load, step;
  logic [ADDR_W-1:0] cur;
  logic              last;

  logic              wen_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [DATA_W-1:0] wdata_n;

  bram_flush_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .start_addr (flush_start),
    .last_addr  (flush_end),
    .cur        (cur),
    .last       (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic and the write-port source mux.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_n  = state;
    load     = 1'b0;
    step     = 1'b0;
    usr_wack = 1'b0;
    wen_n    = 1'b0;
    waddr_n  = bram_waddr;
    wdata_n  = bram_wdata;

    case (state)
      IDLE: begin
        // User port owns the BRAM write port; a write in the same cycle
        // as flush_req is still accepted.
        usr_wack = usr_wen;
        wen_n    = usr_wen;
        if (usr_wen) begin
          waddr_n = usr_waddr;
          wdata_n = usr_wdata;
        end
        if (flush_req) begin
          load    = 1'b1;
          state_n = FLUSH;
        end
      end

      FLUSH: begin
        // This cycle's write issues even when abort arrives with it.
        wen_n   = 1'b1;
        waddr_n = cur;
        wdata_n = FILL_VALUE;
        if (flush_abort)  state_n = ABORT;
        else if (last)    state_n = DONE;
        else              step    = 1'b1;
      end

      // One-cycle status pulse; user writes keep stalling here.
      DONE:    state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered BRAM port: writes from the mux above, reads straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      bram_wen   <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      bram_ren   <= 1'b0;
      bram_raddr <= '0;
    end else begin
      bram_wen   <= wen_n;
      bram_waddr <= waddr_n;
      bram_wdata <= wdata_n;
      bram_ren   <= usr_ren;
      bram_raddr <= usr_raddr;
    end
  end

  // Status flags decode straight from the state register.
  assign flush_busy    = (state == FLUSH);
  assign flush_done    = (state == DONE);
  assign flush_aborted = (state == ABORT);

endmodule : bram_flush_ctrl

// File: tb/tb_bram_flush_ctrl.sv
// Self-checking bench for bram_flush_ctrl: a cycle table for a basic flush
// with user stall and read pass-through, then directed wrap, abort and
// mid-flush reset sequences.
module tb_bram_flush_ctrl;

  localparam int             AW = 10;
  localparam int             DW = 36;
  localparam logic [DW-1:0]  F  = 36'hFFFFFFFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_req, flush_abort;
  logic [AW-1:0] flush_start, flush_end;
  logic          flush_busy, flush_done, flush_aborted;
  logic          usr_wen;
  logic [AW-1:0] usr_waddr;
  logic [DW-1:0] usr_wdata;
  logic          usr_wack;
  logic          usr_ren;
  logic [AW-1:0] usr_raddr;
  logic          bram_wen;
  logic [AW-1:0] bram_waddr;
  logic [DW-1:0] bram_wdata;
  logic          bram_ren;
  logic [AW-1:0] bram_raddr;

  int n_checks = 0;
  int n_fail   = 0;

  bram_flush_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush_req     (flush_req),
    .flush_abort   (flush_abort),
    .flush_start   (flush_start),
    .flush_end     (flush_end),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .flush_aborted (flush_aborted),
    .usr_wen       (usr_wen),
    .usr_waddr     (usr_waddr),
    .usr_wdata     (usr_wdata),
    .usr_wack      (usr_wack),
    .usr_ren       (usr_ren),
    .usr_raddr     (usr_raddr),
    .bram_wen      (bram_wen),
    .bram_waddr    (bram_waddr),
    .bram_wdata    (bram_wdata),
    .bram_ren      (bram_ren),
    .bram_raddr    (bram_raddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One row = inputs held for one cycle plus what must be seen in that cycle
  // (state flags and wack for this cycle, BRAM port from the previous one).
  typedef struct {
    logic          req;
    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ren;
    logic [AW-1:0] ra;
    logic          e_busy;
    logic          e_done;
    logic          e_wack;
    logic          e_bwen;
    logic [AW-1:0] e_bwa;
    logic [DW-1:0] e_bwd;
    logic          e_bren;
    logic [AW-1:0] e_bra;
  } vec_t;

  vec_t vec [9];

  // Collected writes of a directed flush run.
  logic [AW-1:0] wq [$];
  int done_cnt, abt_cnt, busy_cnt, data_bad;

  // Issue a flush of st..en and observe a fixed window of cycles; abort_at>0
  // raises flush_abort during that flush cycle (1-based).
  task automatic run_flush(input logic [AW-1:0] st, input logic [AW-1:0] en,
                           input int abort_at, input int window);
    wq.delete();
    done_cnt = 0; abt_cnt = 0; busy_cnt = 0; data_bad = 0;
    flush_start = st;
    flush_end   = en;
    flush_req   = 1'b1;
    tick();
    flush_req   = 1'b0;
    for (int c = 0; c < window; c++) begin
      if (flush_busy) busy_cnt++;
      flush_abort = flush_busy && (busy_cnt == abort_at);
      if (bram_wen) begin
        wq.push_back(bram_waddr);
        if (bram_wdata !== F) data_bad++;
      end
      if (flush_done)    done_cnt++;
      if (flush_aborted) abt_cnt++;
      tick();
    end
    flush_abort = 1'b0;
  endtask

  task automatic check_writes(input string name, input logic [AW-1:0] exp [$]);
    logic [AW-1:0] got;
    check({name, "_count"}, 64'(wq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      check($sformatf("%s_addr%0d", name, i), 64'(got), 64'(exp[i]));
    end
    check({name, "_data"}, 64'(data_bad), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] exp_w [$];

    //         req wen  wa    wd              ren ra | busy done wack bwen bwa  bwd             bren bra
    vec[0] = '{1'b1, 1'b1, 10'd100, 36'h123456789, 1'b1, 10'd10, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   36'h0,         1'b0, 10'd0};
    vec[1] = '{1'b0, 1'b1, 10'd200, 36'hABC,       1'b0, 10'd11, 1'b1, 1'b0, 1'b0, 1'b1, 10'd100, 36'h123456789, 1'b1, 10'd10};
    vec[2] = '{1'b0, 1'b1, 10'd200, 36'hABC,       1'b1, 10'd12, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0,   F,             1'b0, 10'd11};
    vec[3] = '{1'b0, 1'b1, 10'd200, 36'hABC,       1'b1, 10'd13, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1,   F,             1'b1, 10'd12};
    vec[4] = '{1'b0, 1'b1, 10'd200, 36'hABC,       1'b0, 10'd14, 1'b1, 1'b0, 1'b0, 1'b1, 10'd2,   F,             1'b1, 10'd13};
    vec[5] = '{1'b0, 1'b1, 10'd200, 36'hABC,       1'b1, 10'd15, 1'b0, 1'b1, 1'b0, 1'b1, 10'd3,   F,             1'b0, 10'd14};
    vec[6] = '{1'b0, 1'b1, 10'd200, 36'hABC,       1'b0, 10'd16, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   36'h0,         1'b1, 10'd15};
    vec[7] = '{1'b0, 1'b0, 10'd0,   36'h0,         1'b1, 10'd17, 1'b0, 1'b0, 1'b0, 1'b1, 10'd200, 36'hABC,       1'b0, 10'd16};
    vec[8] = '{1'b0, 1'b0, 10'd0,   36'h0,         1'b0, 10'd18, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   36'h0,         1'b1, 10'd17};

    reset = 1'b1;
    flush_req = 1'b0; flush_abort = 1'b0; flush_start = '0; flush_end = '0;
    usr_wen = 1'b0; usr_waddr = '0; usr_wdata = '0; usr_ren = 1'b0; usr_raddr = '0;
    tick();
    tick();

    // Reset state.
    check("rst_busy",    64'(flush_busy),    64'd0);
    check("rst_done",    64'(flush_done),    64'd0);
    check("rst_aborted", 64'(flush_aborted), 64'd0);
    check("rst_wack",    64'(usr_wack),      64'd0);
    check("rst_bwen",    64'(bram_wen),      64'd0);
    check("rst_bwaddr",  64'(bram_waddr),    64'd0);
    check("rst_bwdata",  64'(bram_wdata),    64'd0);
    check("rst_bren",    64'(bram_ren),      64'd0);
    check("rst_braddr",  64'(bram_raddr),    64'd0);
    reset = 1'b0;

    // Flush 0..3 with a held user write and toggling reads.
    flush_start = 10'd0;
    flush_end   = 10'd3;
    for (int i = 0; i < 9; i++) begin
      flush_req = vec[i].req;
      usr_wen   = vec[i].wen;
      usr_waddr = vec[i].wa;
      usr_wdata = vec[i].wd;
      usr_ren   = vec[i].ren;
      usr_raddr = vec[i].ra;
      #1;
      check($sformatf("v%0d_busy", i),    64'(flush_busy),    64'(vec[i].e_busy));
      check($sformatf("v%0d_done", i),    64'(flush_done),    64'(vec[i].e_done));
      check($sformatf("v%0d_aborted", i), 64'(flush_aborted), 64'd0);
      check($sformatf("v%0d_wack", i),    64'(usr_wack),      64'(vec[i].e_wack));
      check($sformatf("v%0d_bwen", i),    64'(bram_wen),      64'(vec[i].e_bwen));
      if (vec[i].e_bwen) begin
        check($sformatf("v%0d_bwaddr", i), 64'(bram_waddr), 64'(vec[i].e_bwa));
        check($sformatf("v%0d_bwdata", i), 64'(bram_wdata), 64'(vec[i].e_bwd));
      end
      check($sformatf("v%0d_bren", i),    64'(bram_ren),      64'(vec[i].e_bren));
      check($sformatf("v%0d_braddr", i),  64'(bram_raddr),    64'(vec[i].e_bra));
      tick();
    end
    usr_ren = 1'b0;

    // Wrap across the top of the address space.
    run_flush(10'd1022, 10'd1, 0, 10);
    exp_w = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    check_writes("wrap", exp_w);
    check("wrap_busy",  64'(busy_cnt), 64'd4);
    check("wrap_done",  64'(done_cnt), 64'd1);
    check("wrap_abort", 64'(abt_cnt),  64'd0);

    // Abort on the third flush cycle of 0..15.
    run_flush(10'd0, 10'd15, 3, 10);
    exp_w = '{10'd0, 10'd1, 10'd2};
    check_writes("abort", exp_w);
    check("abort_done",  64'(done_cnt), 64'd0);
    check("abort_pulse", 64'(abt_cnt),  64'd1);

    // Abort coinciding with the last address wins over completion.
    run_flush(10'd4, 10'd6, 3, 8);
    exp_w = '{10'd4, 10'd5, 10'd6};
    check_writes("abort_last", exp_w);
    check("abort_last_done",  64'(done_cnt), 64'd0);
    check("abort_last_pulse", 64'(abt_cnt),  64'd1);

    // Reset in the middle of a flush.
    flush_start = 10'd0;
    flush_end   = 10'd15;
    flush_req   = 1'b1;
    tick();
    flush_req   = 1'b0;
    tick();
    tick();
    check("mid_busy_before", 64'(flush_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_bwen",    64'(bram_wen),      64'd0);
    check("mid_rst_busy",    64'(flush_busy),    64'd0);
    check("mid_rst_done",    64'(flush_done),    64'd0);
    check("mid_rst_aborted", 64'(flush_aborted), 64'd0);
    done_cnt = 0; abt_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (flush_done || flush_aborted || flush_busy || bram_wen) done_cnt++;
      tick();
    end
    check("mid_rst_quiet", 64'(done_cnt), 64'd0);

    // Single-word flush after the reset.
    run_flush(10'd5, 10'd5, 0, 6);
    exp_w = '{10'd5};
    check_writes("single", exp_w);
    check("single_busy", 64'(busy_cnt), 64'd1);
    check("single_done", 64'(done_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bram_flush_ctrl
